// File: rtl/ocs_pkg.sv
// ocs_pkg: state encoding, default timing constants and width helper for overcurrent_supervisor.
`default_nettype none

package ocs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_BLANK    = 3'd1,
    ST_RUN      = 3'd2,
    ST_COOLDOWN = 3'd3,
    ST_LOCKOUT  = 3'd4
  } ocs_state_t;

  localparam int unsigned C_DEF_COOLDOWN_CYCLES  = 5000000;
  localparam int unsigned C_DEF_SOFTSTART_CYCLES = 500000;
  localparam int unsigned C_DEF_MAX_RETRIES      = 3;

  // Bits needed to hold values 0..v-1, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cycle_timer.sv
// cycle_timer: saturating up-counter cleared by load_i, flags when count reaches limit_i.
`default_nettype none

module cycle_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q >= limit_i);

endmodule

`default_nettype wire

// File: rtl/overcurrent_supervisor.sv
// overcurrent_supervisor: power-stage enable with trip cooldown, bounded auto-retry and lockout.
// Macro OCS_SOFTSTART_EN adds the inrush blanking state (BLANK) after every power-on.
`default_nettype none

module overcurrent_supervisor
  import ocs_pkg::*;
#(
  parameter int unsigned COOLDOWN_CYCLES  = C_DEF_COOLDOWN_CYCLES,
  parameter int unsigned SOFTSTART_CYCLES = C_DEF_SOFTSTART_CYCLES,
  parameter int unsigned MAX_RETRIES      = C_DEF_MAX_RETRIES
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   enable_req,
  input  logic                                   current_high,
  input  logic                                   clear_fault,
  output logic                                   pwr_en,
  output logic                                   fault_latched,
  output logic [clog2_min1(MAX_RETRIES+1)-1:0]   retry_count,
  output logic [2:0]                             state_o
);

  localparam int unsigned RW      = clog2_min1(MAX_RETRIES + 1);
  // Terminal count fires with the timer at N-1, giving exactly N cycles in the state.
  localparam int unsigned CD_LIM  = (COOLDOWN_CYCLES  > 0) ? COOLDOWN_CYCLES  - 1 : 0;
  localparam int unsigned SS_LIM  = (SOFTSTART_CYCLES > 0) ? SOFTSTART_CYCLES - 1 : 0;
  localparam int unsigned MAX_LIM = (CD_LIM > SS_LIM) ? CD_LIM : SS_LIM;
  localparam int unsigned TW      = clog2_min1(MAX_LIM + 1);

`ifdef OCS_SOFTSTART_EN
  localparam ocs_state_t C_START_STATE = ST_BLANK;
`else
  localparam ocs_state_t C_START_STATE = ST_RUN;
`endif

  ocs_state_t    state_q, state_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          pwr_en_q;
  logic          fault_q;
  logic          tmr_load;
  logic          tmr_tc;
  logic [TW-1:0] tmr_limit;

  assign tmr_load  = (state_d != state_q);
  assign tmr_limit = (state_q == ST_BLANK) ? TW'(SS_LIM) : TW'(CD_LIM);

  cycle_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (tmr_load),
    .enable_i (1'b1),
    .limit_i  (tmr_limit),
    .tc_o     (tmr_tc)
  );

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    case (state_q)
      ST_IDLE: begin
        if (enable_req) state_d = C_START_STATE;
      end
`ifdef OCS_SOFTSTART_EN
      ST_BLANK: begin
        if (!enable_req)  state_d = ST_IDLE;
        else if (tmr_tc)  state_d = ST_RUN;
      end
`endif
      ST_RUN: begin
        // A trip takes priority over a simultaneous host disable.
        if (current_high) begin
          if (retry_q < RW'(MAX_RETRIES)) begin
            state_d = ST_COOLDOWN;
            retry_d = retry_q + 1'b1;
          end else begin
            state_d = ST_LOCKOUT;
          end
        end else if (!enable_req) begin
          state_d = ST_IDLE;
        end
      end
      ST_COOLDOWN: begin
        if (tmr_tc) state_d = enable_req ? C_START_STATE : ST_IDLE;
      end
      ST_LOCKOUT: begin
        if (clear_fault && !enable_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_IDLE) retry_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      retry_q  <= '0;
      pwr_en_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      retry_q  <= retry_d;
      pwr_en_q <= (state_d == ST_RUN) || (state_d == ST_BLANK);
      fault_q  <= (state_d == ST_LOCKOUT);
    end
  end

  assign pwr_en        = pwr_en_q;
  assign fault_latched = fault_q;
  assign retry_count   = retry_q;
  assign state_o       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_overcurrent_supervisor.sv
// tb_overcurrent_supervisor: directed stimulus with a per-cycle expected-output scoreboard.
`default_nettype none

module tb_overcurrent_supervisor;

  logic       clk;
  logic       rst;
  logic       enable_req;
  logic       current_high;
  logic       clear_fault;
  logic       pwr_en;
  logic       fault_latched;
  logic [1:0] retry_count;
  logic [2:0] state_o;

  typedef struct packed {
    logic [2:0] st;
    logic       pwr;
    logic       flt;
    logic [1:0] rc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks;
  int   n_fail;

`ifdef OCS_SOFTSTART_EN
  localparam logic [2:0] START_ST = 3'd1;
`else
  localparam logic [2:0] START_ST = 3'd2;
`endif

  overcurrent_supervisor #(
    .COOLDOWN_CYCLES  (10),
    .SOFTSTART_CYCLES (4),
    .MAX_RETRIES      (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable_req    (enable_req),
    .current_high  (current_high),
    .clear_fault   (clear_fault),
    .pwr_en        (pwr_en),
    .fault_latched (fault_latched),
    .retry_count   (retry_count),
    .state_o       (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs for the next rising edge and queue the outputs expected after it.
  task automatic step(input logic en, input logic ch, input logic cf,
                      input logic [2:0] st, input logic [1:0] rc);
    exp_t e;
    @(negedge clk);
    #1;
    enable_req   = en;
    current_high = ch;
    clear_fault  = cf;
    e.st  = st;
    e.pwr = (st == 3'd1) || (st == 3'd2);
    e.flt = (st == 3'd4);
    e.rc  = rc;
    sb_q.push_back(e);
  endtask

  // Power-up from IDLE or COOLDOWN expiry; a current_high pulse lands inside BLANK.
  task automatic restart(input logic [1:0] rc);
    step(1'b1, 1'b0, 1'b0, START_ST, rc);
`ifdef OCS_SOFTSTART_EN
    step(1'b1, 1'b1, 1'b0, 3'd1, rc);
    step(1'b1, 1'b0, 1'b0, 3'd1, rc);
    step(1'b1, 1'b0, 1'b0, 3'd1, rc);
    step(1'b1, 1'b0, 1'b0, 3'd2, rc);
`endif
  endtask

  // Remaining nine cooldown cycles after the trip cycle; enable_req dips mid-dwell.
  task automatic cool(input logic [1:0] rc, input logic en_hold);
    for (int i = 0; i < 9; i++) begin
      step(en_hold && (i != 4), 1'b0, 1'b0, 3'd3, rc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if ({state_o, pwr_en, fault_latched, retry_count} !== e) begin
        n_fail++;
        $display("FAIL outputs @%0t: got st=%0d pwr=%0b flt=%0b rc=%0d, want st=%0d pwr=%0b flt=%0b rc=%0d",
                 $time, state_o, pwr_en, fault_latched, retry_count, e.st, e.pwr, e.flt, e.rc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    enable_req   = 1'b0;
    current_high = 1'b0;
    clear_fault  = 1'b0;
    #2;
    n_checks++;
    if ({state_o, pwr_en, fault_latched, retry_count} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_state: got st=%0d pwr=%0b flt=%0b rc=%0d, want all zero",
               state_o, pwr_en, fault_latched, retry_count);
    end
    #10;
    rst = 1'b0;

    step(1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
    restart(2'd0);
    step(1'b1, 1'b0, 1'b0, 3'd2, 2'd0);

    step(1'b1, 1'b1, 1'b0, 3'd3, 2'd1);
    cool(2'd1, 1'b1);
    restart(2'd1);
    step(1'b1, 1'b1, 1'b0, 3'd3, 2'd2);
    cool(2'd2, 1'b1);
    restart(2'd2);
    step(1'b1, 1'b1, 1'b0, 3'd4, 2'd2);
    step(1'b1, 1'b0, 1'b1, 3'd4, 2'd2);
    step(1'b0, 1'b0, 1'b0, 3'd4, 2'd2);
    step(1'b0, 1'b0, 1'b1, 3'd0, 2'd0);

    restart(2'd0);
    step(1'b0, 1'b1, 1'b0, 3'd3, 2'd1);
    cool(2'd1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 3'd0, 2'd0);

    restart(2'd0);
    step(1'b0, 1'b0, 1'b0, 3'd0, 2'd0);

    restart(2'd0);
    step(1'b1, 1'b1, 1'b0, 3'd3, 2'd1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 3'd3, 2'd1);
    @(negedge clk);
    #2;
    rst        = 1'b1;
    enable_req = 1'b0;
    #1;
    n_checks++;
    if ({state_o, pwr_en, fault_latched, retry_count} !== 7'b0) begin
      n_fail++;
      $display("FAIL async_reset_cooldown: got st=%0d pwr=%0b flt=%0b rc=%0d, want all zero",
               state_o, pwr_en, fault_latched, retry_count);
    end
    #1;
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
    restart(2'd0);
    step(1'b0, 1'b0, 1'b0, 3'd0, 2'd0);

    repeat (3) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
